// File: rtl/rf_wb_unit.sv
// rtl/rf_wb_unit.sv - register file writeback arbiter, load formatter and busy scoreboard
module rf_wb_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  input  logic [ADDR_WIDTH-1:0]      issue_rd,
  output logic [(1<<ADDR_WIDTH)-1:0] busy,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_WIDTH-1:0]      alu_rd,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [ADDR_WIDTH-1:0]      lsu_rd,
  input  logic [DATA_WIDTH-1:0]      lsu_data,
  input  logic [1:0]                 lsu_size,
  input  logic                       lsu_unsigned,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  output logic                       idle
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic                  rf_wen_q,   rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]       busy_q,     busy_d;
  // last_lsu_q = 1 when the LSU won the most recent transfer
  logic                  last_lsu_q, last_lsu_d;

  logic                  grant_lsu;
  logic                  fill;
  logic [DATA_WIDTH-1:0] lsu_fmt;

  // Round-robin grant: a lone valid always wins, a tie goes to the source not granted last
  always_comb begin
    grant_lsu = lsu_valid && (!alu_valid || !last_lsu_q);
    lsu_ready = rst_n && grant_lsu;
    alu_ready = rst_n && alu_valid && !grant_lsu;
  end

  // Load data extension to the full register width
  always_comb begin
    fill    = 1'b0;
    lsu_fmt = lsu_data;
    case (lsu_size)
      2'b00: begin
        fill    = !lsu_unsigned && lsu_data[7];
        lsu_fmt = {{(DATA_WIDTH-8){fill}}, lsu_data[7:0]};
      end
      2'b01: begin
        fill    = !lsu_unsigned && lsu_data[15];
        lsu_fmt = {{(DATA_WIDTH-16){fill}}, lsu_data[15:0]};
      end
      2'b10: begin
        fill    = !lsu_unsigned && lsu_data[31];
        lsu_fmt = {{(DATA_WIDTH-32){fill}}, lsu_data[31:0]};
      end
      default: lsu_fmt = lsu_data;
    endcase
  end

  // Next state of the output stage, arbitration pointer and scoreboard
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    last_lsu_d = last_lsu_q;
    if (lsu_ready) begin
      rf_wen_d   = (lsu_rd != '0);
      rf_waddr_d = lsu_rd;
      rf_wdata_d = lsu_fmt;
      last_lsu_d = 1'b1;
    end else if (alu_ready) begin
      rf_wen_d   = (alu_rd != '0);
      rf_waddr_d = alu_rd;
      rf_wdata_d = alu_data;
      last_lsu_d = 1'b0;
    end

    // Clear first so that a same-edge issue to the same register keeps it busy
    busy_d = busy_q;
    if (rf_wen_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
      last_lsu_q <= 1'b0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
      last_lsu_q <= last_lsu_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;
  assign idle     = (busy_q == '0) && !rf_wen_q;

endmodule

// File: tb/tb_rf_wb_unit.sv
// tb/tb_rf_wb_unit.sv - self-checking bench for rf_wb_unit
module tb_rf_wb_unit;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        idle;

  rf_wb_unit dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    logic [1:0]  size;
    logic        uns;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic wen, input logic [4:0] addr, input logic [63:0] data);
    wr_t w;
    w.wen = wen; w.addr = addr; w.data = data;
    exp_q.push_back(w);
  endtask

  // Advance one edge, then compare the output stage against the scoreboard
  task automatic tick();
    wr_t w;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("rf_wen", rf_wen, w.wen);
      chk("rf_waddr", rf_waddr, w.addr);
      chk("rf_wdata", rf_wdata, w.data);
    end else begin
      chk("rf_wen_quiet", rf_wen, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{2'b00, 1'b0, 64'h0000_0000_0000_0080, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1] = '{2'b00, 1'b1, 64'h0000_0000_0000_0080, 64'h0000_0000_0000_0080};
    vecs[2] = '{2'b10, 1'b0, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001};
    vecs[3] = '{2'b10, 1'b1, 64'h0000_0001_8000_0001, 64'h0000_0000_8000_0001};
    vecs[4] = '{2'b01, 1'b0, 64'hAAAA_AAAA_AAAA_8001, 64'hFFFF_FFFF_FFFF_8001};
    vecs[5] = '{2'b01, 1'b1, 64'hAAAA_AAAA_AAAA_8001, 64'h0000_0000_0000_8001};
    vecs[6] = '{2'b01, 1'b0, 64'hFFFF_FFFF_1234_7FFF, 64'h0000_0000_0000_7FFF};
    vecs[7] = '{2'b00, 1'b0, 64'h0000_0000_0000_017F, 64'h0000_0000_0000_007F};
    vecs[8] = '{2'b11, 1'b1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};

    rst_n = 1'b0; issue_valid = 1'b0; issue_rd = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 64'h0; lsu_size = 2'b00; lsu_unsigned = 1'b0;

    // Reset with a pending ALU valid
    #1;
    chk("alu_ready_in_reset", alu_ready, 1'b0);
    tick();
    tick();
    chk("alu_ready_in_reset2", alu_ready, 1'b0);
    chk("busy_reset", busy, 32'h0);
    chk("idle_reset", idle, 1'b1);

    // First ALU transfer after release
    rst_n = 1'b1;
    #1;
    chk("alu_ready_first", alu_ready, 1'b1);
    chk("lsu_ready_first", lsu_ready, 1'b0);
    push(1'b1, 5'd5, 64'h1234);
    tick();
    alu_valid = 1'b0;
    tick();
    chk("waddr_hold", rf_waddr, 5'd5);
    chk("wdata_hold", rf_wdata, 64'h1234);

    // Load extension table
    for (int i = 0; i < 9; i++) begin
      lsu_valid = 1'b1;
      lsu_rd = 5'(i + 1);
      lsu_size = vecs[i].size;
      lsu_unsigned = vecs[i].uns;
      lsu_data = vecs[i].din;
      #1;
      chk("lsu_ready_vec", lsu_ready, 1'b1);
      chk("alu_ready_vec", alu_ready, 1'b0);
      push(1'b1, 5'(i + 1), vecs[i].exp);
      tick();
    end
    lsu_valid = 1'b0;
    tick();

    // Contention from a fresh pointer: LSU, ALU, LSU, ALU
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 64'hAAAA_0000_0000_000A;
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 64'hBBBB_0000_0000_000B;
    lsu_size = 2'b11; lsu_unsigned = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("cont_lsu_ready", lsu_ready, (c % 2) == 0);
      chk("cont_alu_ready", alu_ready, (c % 2) == 1);
      chk("cont_not_both", alu_ready & lsu_ready, 1'b0);
      if ((c % 2) == 0) push(1'b1, 5'd11, 64'hBBBB_0000_0000_000B);
      else              push(1'b1, 5'd10, 64'hAAAA_0000_0000_000A);
      tick();
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();

    // Scoreboard set, then clear one cycle after rf_wen
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    chk("busy7_set", busy[7], 1'b1);
    chk("idle_busy", idle, 1'b0);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
    push(1'b1, 5'd7, 64'h77);
    tick();
    alu_valid = 1'b0;
    chk("busy7_during_wen", busy[7], 1'b1);
    tick();
    chk("busy7_cleared", busy[7], 1'b0);
    chk("idle_after_clear", idle, 1'b1);

    // Issue to the register being cleared on the same edge: set wins
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1;
    push(1'b1, 5'd7, 64'h77);
    tick();
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    chk("busy7_set_wins", busy[7], 1'b1);

    // Clear x7 while issuing x9 on the same edge: both apply
    alu_valid = 1'b1;
    push(1'b1, 5'd7, 64'h77);
    tick();
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    chk("busy7_clear_other", busy[7], 1'b0);
    chk("busy9_set_other", busy[9], 1'b1);

    // Reset mid-flight discards the pending write and busy bits
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
    push(1'b1, 5'd3, 64'h33);
    tick();
    alu_valid = 1'b0;
    chk("busy3_pending", busy[3], 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("busy_midreset", busy, 32'h0);
    chk("idle_midreset", idle, 1'b1);
    chk("waddr_midreset", rf_waddr, 5'd0);
    chk("wdata_midreset", rf_wdata, 64'h0);

    // x0 writes are accepted but never enable the port; x0 never goes busy
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hDEAD;
    #1;
    chk("x0_alu_ready", alu_ready, 1'b1);
    push(1'b0, 5'd0, 64'hDEAD);
    tick();
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    issue_valid = 1'b0;
    chk("busy0_zero", busy, 32'h0);
    chk("idle_x0", idle, 1'b1);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
